// File: rtl/uart_io_arbiter.sv
// Arbitrates the single UART between the processor IO port (never stalled) and a
// debug/loader monitor with a valid/ready handshake; owns the IO port map and read return.
module uart_io_arbiter #(
  parameter logic [7:0] UART_PORT = 8'h01,
  parameter logic [7:0] RXP_PORT  = 8'h02,
  parameter logic [7:0] TXF_PORT  = 8'h03,
  parameter logic [7:0] OVF_PORT  = 8'h04,
  parameter logic [7:0] OWN_PORT  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  // processor side
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  // debug monitor side
  input  logic       dbg_req_valid,
  input  logic       dbg_req_write,
  input  logic [7:0] dbg_port_ID,
  input  logic [7:0] dbg_write_data,
  output logic       dbg_req_ready,
  output logic       dbg_rsp_valid,
  output logic [7:0] dbg_rsp_data,
  // UART side
  output logic [7:0] uart_tx_data,
  output logic       uart_write,
  input  logic       uart_tx_full,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_present,
  output logic       uart_read_ack
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } dbg_state_t;

  dbg_state_t state, state_next;

  logic       p_access;
  logic       acc_valid;
  logic       acc_write;
  logic       acc_read;
  logic       acc_is_dbg;
  logic [7:0] acc_port;
  logic [7:0] acc_wdata;
  logic       is_owner;
  logic       overflow;
  logic       dbg_clear_ovf;
  logic [7:0] read_value;

  logic       rx_owner;
  logic [7:0] ovf_count;

  // Both strobes in one cycle count as a single write; the read is dropped.
  assign p_access = IO_read_strobe | IO_write_strobe;

  // NOTE: every signal driven from always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    dbg_req_ready = 1'b0;
    dbg_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        dbg_req_ready = dbg_req_valid & ~p_access;
        if (dbg_req_ready) state_next = RESP;
      end
      RESP: begin
        dbg_rsp_valid = 1'b1;
        state_next    = IDLE;
      end
    endcase
  end

  // Select the single access that executes this cycle.
  always_comb begin
    acc_is_dbg = ~p_access;
    acc_valid  = p_access | dbg_req_ready;
    if (p_access) begin
      acc_port  = IO_port_ID;
      acc_wdata = IO_write_data;
      acc_write = IO_write_strobe;
    end else begin
      acc_port  = dbg_port_ID;
      acc_wdata = dbg_write_data;
      acc_write = dbg_req_write;
    end
    acc_write = acc_write & acc_valid;
    acc_read  = acc_valid & ~acc_write;
  end

  assign is_owner      = (rx_owner == acc_is_dbg);
  assign uart_write    = acc_write & (acc_port == UART_PORT) & ~uart_tx_full;
  assign uart_tx_data  = uart_write ? acc_wdata : 8'h00;
  assign overflow      = acc_write & (acc_port == UART_PORT) & uart_tx_full;
  assign dbg_clear_ovf = acc_read & acc_is_dbg & (acc_port == OVF_PORT);

  // The RX path is hidden from whoever does not own it.
  always_comb begin
    read_value = 8'h00;
    case (acc_port)
      UART_PORT: read_value = is_owner ? uart_rx_data : 8'h00;
      RXP_PORT:  read_value = is_owner ? {7'b0, uart_rx_present} : 8'h00;
      TXF_PORT:  read_value = {7'b0, uart_tx_full};
      OVF_PORT:  read_value = ovf_count;
      OWN_PORT:  read_value = {7'b0, rx_owner};
      default:   read_value = 8'h00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IO_read_data  <= 8'h00;
      dbg_rsp_data  <= 8'h00;
      uart_read_ack <= 1'b0;
    end else begin
      if (IO_read_strobe && !IO_write_strobe) IO_read_data <= read_value;
      if (dbg_req_ready && !dbg_req_write)    dbg_rsp_data <= read_value;
      uart_read_ack <= acc_read & (acc_port == UART_PORT) & is_owner & uart_rx_present;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_owner <= 1'b0;
    end else if (acc_write && acc_is_dbg && (acc_port == OWN_PORT)) begin
      rx_owner <= acc_wdata[0];
    end
  end

  // A monitor read of the counter clears it, but a coincident overflow still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= 8'h00;
    end else if (dbg_clear_ovf) begin
      ovf_count <= overflow ? 8'h01 : 8'h00;
    end else if (overflow && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_uart_io_arbiter.sv
// Directed bench for uart_io_arbiter: a cycle-level behavioural model is compared
// against the DUT on every cycle, alongside hand-computed expectations.
module tb_uart_io_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;
  logic       dbg_req_valid;
  logic       dbg_req_write;
  logic [7:0] dbg_port_ID;
  logic [7:0] dbg_write_data;
  logic       dbg_req_ready;
  logic       dbg_rsp_valid;
  logic [7:0] dbg_rsp_data;
  logic [7:0] uart_tx_data;
  logic       uart_write;
  logic       uart_tx_full;
  logic [7:0] uart_rx_data;
  logic       uart_rx_present;
  logic       uart_read_ack;

  int checks = 0;
  int errors = 0;

  uart_io_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .IO_port_ID     (IO_port_ID),
    .IO_write_data  (IO_write_data),
    .IO_write_strobe(IO_write_strobe),
    .IO_read_strobe (IO_read_strobe),
    .IO_read_data   (IO_read_data),
    .dbg_req_valid  (dbg_req_valid),
    .dbg_req_write  (dbg_req_write),
    .dbg_port_ID    (dbg_port_ID),
    .dbg_write_data (dbg_write_data),
    .dbg_req_ready  (dbg_req_ready),
    .dbg_rsp_valid  (dbg_rsp_valid),
    .dbg_rsp_data   (dbg_rsp_data),
    .uart_tx_data   (uart_tx_data),
    .uart_write     (uart_write),
    .uart_tx_full   (uart_tx_full),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_present(uart_rx_present),
    .uart_read_ack  (uart_read_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_owner;     // who may see RX: 0 processor, 1 monitor
  logic [7:0] m_ovf;
  logic [7:0] m_io_rd;
  logic [7:0] m_rsp_data;
  logic       m_rsp_valid; // monitor response on show; monitor cannot be accepted then
  logic       m_ack;

  function automatic logic [7:0] model_read(input logic [7:0] port, input logic by_dbg);
    logic mine;
    mine = (m_owner == by_dbg);
    case (port)
      8'h01:   return mine ? uart_rx_data : 8'h00;
      8'h02:   return mine ? {7'b0, uart_rx_present} : 8'h00;
      8'h03:   return {7'b0, uart_tx_full};
      8'h04:   return m_ovf;
      8'hFF:   return {7'b0, m_owner};
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic       p_acc, d_acc, by_dbg, wr, rd, ovfl;
    logic [7:0] port, data, val;
    if (reset) begin
      m_owner     <= 1'b0;
      m_ovf       <= 8'h00;
      m_io_rd     <= 8'h00;
      m_rsp_data  <= 8'h00;
      m_rsp_valid <= 1'b0;
      m_ack       <= 1'b0;
    end else begin
      p_acc  = IO_read_strobe || IO_write_strobe;
      d_acc  = !m_rsp_valid && dbg_req_valid && !p_acc;
      by_dbg = !p_acc;
      port   = p_acc ? IO_port_ID : dbg_port_ID;
      data   = p_acc ? IO_write_data : dbg_write_data;
      wr     = p_acc ? IO_write_strobe : (d_acc && dbg_req_write);
      rd     = (p_acc || d_acc) && !wr;
      val    = model_read(port, by_dbg);
      ovfl   = wr && port == 8'h01 && uart_tx_full;
      if (p_acc && rd) m_io_rd <= val;
      if (d_acc && rd) m_rsp_data <= val;
      m_ack <= rd && port == 8'h01 && (m_owner == by_dbg) && uart_rx_present;
      if (d_acc && rd && port == 8'h04) m_ovf <= ovfl ? 8'h01 : 8'h00;
      else if (ovfl) m_ovf <= (m_ovf == 8'hFF) ? 8'hFF : m_ovf + 8'h01;
      if (d_acc && wr && port == 8'hFF) m_owner <= data[0];
      m_rsp_valid <= d_acc;
    end
  end

  // Compare every cycle, mid-cycle when inputs have settled.
  always @(negedge clk) begin : compare
    logic       p_acc, e_ready, e_wr;
    logic [7:0] e_tx;
    #2;
    p_acc   = IO_read_strobe || IO_write_strobe;
    e_ready = !m_rsp_valid && dbg_req_valid && !p_acc;
    e_wr    = (IO_write_strobe && IO_port_ID == 8'h01 && !uart_tx_full) ||
              (e_ready && dbg_req_write && dbg_port_ID == 8'h01 && !uart_tx_full);
    e_tx    = !e_wr ? 8'h00 : (IO_write_strobe ? IO_write_data : dbg_write_data);
    check("model_ready",    dbg_req_ready, e_ready);
    check("model_uwrite",   uart_write,    e_wr);
    check("model_txdata",   uart_tx_data,  e_tx);
    check("model_io_rd",    IO_read_data,  m_io_rd);
    check("model_rsp_val",  dbg_rsp_valid, m_rsp_valid);
    check("model_rsp_data", dbg_rsp_data,  m_rsp_data);
    check("model_ack",      uart_read_ack, m_ack);
  end

  // ---------------- directed stimulus ----------------
  task automatic p_write(input logic [7:0] port, input logic [7:0] data,
                         input logic exp_wr, input logic [7:0] exp_tx);
    @(negedge clk);
    IO_write_strobe = 1'b1; IO_port_ID = port; IO_write_data = data;
    #1;
    check("p_wr_uwrite", uart_write, exp_wr);
    check("p_wr_txdata", uart_tx_data, exp_tx);
    @(negedge clk);
    IO_write_strobe = 1'b0;
  endtask

  task automatic p_read(input logic [7:0] port, input logic [7:0] exp);
    @(negedge clk);
    IO_read_strobe = 1'b1; IO_port_ID = port;
    @(negedge clk);
    IO_read_strobe = 1'b0;
    #2;
    check("p_rd_data", IO_read_data, exp);
  endtask

  // Returns at the falling edge inside the response cycle.
  task automatic d_req(input logic wr, input logic [7:0] port, input logic [7:0] data);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    dbg_req_valid = 1'b1; dbg_req_write = wr; dbg_port_ID = port; dbg_write_data = data;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      acc = dbg_req_ready;
      @(negedge clk);
    end
    dbg_req_valid = 1'b0;
    if (!acc) check("d_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic d_read(input logic [7:0] port, input logic [7:0] exp);
    d_req(1'b0, port, 8'h00);
    #2;
    check("d_rsp_valid", dbg_rsp_valid, 1'b1);
    check("d_rsp_data", dbg_rsp_data, exp);
  endtask

  initial begin
    reset = 1'b1;
    IO_port_ID = 8'h00; IO_write_data = 8'h00; IO_write_strobe = 1'b0; IO_read_strobe = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_port_ID = 8'h00; dbg_write_data = 8'h00;
    uart_tx_full = 1'b0; uart_rx_data = 8'h00; uart_rx_present = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_io_rd", IO_read_data, 8'h00);
    check("rst_rsp_valid", dbg_rsp_valid, 1'b0);
    check("rst_rsp_data", dbg_rsp_data, 8'h00);
    check("rst_ack", uart_read_ack, 1'b0);
    reset = 1'b0;

    // TX path and overflow count
    p_write(8'h01, 8'h41, 1'b1, 8'h41);
    uart_tx_full = 1'b1;
    p_write(8'h01, 8'h42, 1'b0, 8'h00);
    uart_tx_full = 1'b0;
    d_read(8'h04, 8'h01);
    d_read(8'h04, 8'h00);

    // processor owns RX by default
    uart_rx_present = 1'b1; uart_rx_data = 8'h5A;
    p_read(8'h01, 8'h5A);
    check("p_ack_pulse", uart_read_ack, 1'b1);
    @(negedge clk); #2;
    check("p_ack_single", uart_read_ack, 1'b0);

    // both strobes: a write, read dropped
    @(negedge clk);
    IO_write_strobe = 1'b1; IO_read_strobe = 1'b1; IO_port_ID = 8'h01; IO_write_data = 8'h33;
    #1;
    check("both_uwrite", uart_write, 1'b1);
    check("both_txdata", uart_tx_data, 8'h33);
    @(negedge clk);
    IO_write_strobe = 1'b0; IO_read_strobe = 1'b0;
    #2;
    check("both_io_hold", IO_read_data, 8'h5A);
    check("both_no_ack", uart_read_ack, 1'b0);

    // unmapped ports
    p_write(8'h07, 8'h99, 1'b0, 8'h00);
    p_read(8'h07, 8'h00);

    // processor priority over a waiting monitor
    @(negedge clk);
    dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_port_ID = 8'h02;
    IO_read_strobe = 1'b1; IO_port_ID = 8'h02;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("prio_ready_low", dbg_req_ready, 1'b0);
      @(negedge clk);
    end
    IO_read_strobe = 1'b0;
    #1;
    check("prio_ready_high", dbg_req_ready, 1'b1);
    @(negedge clk);
    dbg_req_valid = 1'b0;
    #1;
    check("prio_rsp_valid", dbg_rsp_valid, 1'b1);
    check("prio_rsp_data", dbg_rsp_data, 8'h00);
    check("prio_io_rxp", IO_read_data, 8'h01);

    // monitor takes RX ownership
    d_req(1'b1, 8'hFF, 8'h01);
    p_read(8'h01, 8'h00);
    check("nonowner_no_ack", uart_read_ack, 1'b0);
    d_read(8'h01, 8'h5A);
    check("d_owner_ack", uart_read_ack, 1'b1);
    p_read(8'hFF, 8'h01);
    p_read(8'h02, 8'h00);
    d_read(8'h02, 8'h01);
    p_write(8'hFF, 8'h00, 1'b0, 8'h00);
    p_read(8'hFF, 8'h01);

    // saturate the overflow counter
    uart_tx_full = 1'b1;
    @(negedge clk);
    IO_write_strobe = 1'b1; IO_port_ID = 8'h01; IO_write_data = 8'hEE;
    repeat (300) @(negedge clk);
    IO_write_strobe = 1'b0;
    p_read(8'h03, 8'h01);
    p_read(8'h04, 8'hFF);
    p_read(8'h04, 8'hFF);
    uart_tx_full = 1'b0;
    d_read(8'h04, 8'hFF);
    d_read(8'h04, 8'h00);

    // reset in the middle of a monitor response
    d_req(1'b0, 8'h01, 8'h00);
    #1;
    check("pre_rst_rsp_valid", dbg_rsp_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", dbg_rsp_valid, 1'b0);
    check("mid_rst_rsp_data", dbg_rsp_data, 8'h00);
    check("mid_rst_io_rd", IO_read_data, 8'h00);
    check("mid_rst_ack", uart_read_ack, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    p_read(8'hFF, 8'h00);
    p_read(8'h01, 8'h5A);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
